// File: rtl/key_debouncer.sv
// key_debouncer: synchronise and debounce raw push-buttons into clean active-high levels
// Ports: clk, reset (sync, active-high); key_raw[N_KEYS] async raw keys;
//        key_clean[N_KEYS] debounced level (1 = pressed); key_busy[N_KEYS] 1 while a key is waiting out a change.
// Build option: define KEY_DEBOUNCE_BYPASS_EN to drop the debounce FSMs (key_clean = synchronised key, key_busy = 0).
module key_debouncer #(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_clean,
  output logic [N_KEYS-1:0] key_busy
);
  localparam logic [N_KEYS-1:0] REL_LVL = {N_KEYS{ACTIVE_LOW != 0}};
  logic [N_KEYS-1:0] sync1, sync2, k;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end
  assign k = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
`ifdef KEY_DEBOUNCE_BYPASS_EN
  assign key_clean = k;
  assign key_busy  = '0;
`else
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
        RELEASED: if (k[i]) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
        PRESS_WAIT:
          if (!k[i]) state_n = RELEASED;
          else if (cnt == CNT_MAX) state_n = PRESSED;
          else cnt_n = cnt + 1'b1;
        PRESSED: if (!k[i]) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
        RELEASE_WAIT:
          if (k[i]) state_n = PRESSED;
          else if (cnt == CNT_MAX) state_n = RELEASED;
          else cnt_n = cnt + 1'b1;
        default: state_n = RELEASED;
      endcase
    end
    assign key_clean[i] = (state == PRESSED) || (state == RELEASE_WAIT);
    assign key_busy[i]  = (state == PRESS_WAIT) || (state == RELEASE_WAIT);
  end
`endif
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench for key_debouncer (STABLE_CYCLES=4, ACTIVE_LOW=1, 4 keys)
module tb_key_debouncer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_clean, key_busy;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  typedef struct {
    int at;
    string tag;
    logic [3:0] clean;
    logic [3:0] busy;
    bit cb;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  key_debouncer #(.N_KEYS(4), .STABLE_CYCLES(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .key_clean(key_clean), .key_busy(key_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  task automatic expect_at(int at, string tag, logic [3:0] c, logic [3:0] b, bit cb);
    sb.push_back('{at, tag, c, b, cb});
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 100) begin
      tick();
      t++;
    end
    check("drain", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at != cyc) check({mon_e.tag, "_sched"}, cyc, mon_e.at);
      check({mon_e.tag, "_clean"}, key_clean, mon_e.clean);
      if (mon_e.cb) check({mon_e.tag, "_busy"}, key_busy, mon_e.busy);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end
  initial begin
    int c;
    tick(2);
    check("rst_clean", key_clean, 4'h0);
    check("rst_busy", key_busy, 4'h0);
    reset = 1'b0;
    c = cyc;
    for (int i = 1; i <= 20; i++) expect_at(c + i, "idle", 4'h0, 4'h0, 1'b1);
    drain();
`ifdef KEY_DEBOUNCE_BYPASS_EN
    c = cyc;
    key_raw[1] = 1'b0;
    expect_at(c + 1, "byp_pre", 4'h0, 4'h0, 1'b1);
    expect_at(c + 2, "byp_press", 4'b0010, 4'h0, 1'b1);
    drain();
    c = cyc;
    key_raw = 4'hF;
    expect_at(c + 1, "byp_hold", 4'b0010, 4'h0, 1'b1);
    expect_at(c + 2, "byp_rel", 4'h0, 4'h0, 1'b1);
    drain();
`else
    // single press latency and busy window
    c = cyc;
    key_raw[0] = 1'b0;
    expect_at(c + 2, "p_pre", 4'h0, 4'h0, 1'b1);
    expect_at(c + 3, "p_busy", 4'h0, 4'h1, 1'b1);
    expect_at(c + 6, "p_last", 4'h0, 4'h1, 1'b1);
    expect_at(c + 7, "p_clean", 4'h1, 4'h0, 1'b1);
    expect_at(c + 10, "p_hold", 4'h1, 4'h0, 1'b1);
    drain();
    c = cyc;
    key_raw[0] = 1'b1;
    expect_at(c + 6, "r_last", 4'h1, 4'h1, 1'b1);
    expect_at(c + 7, "r_clean", 4'h0, 4'h0, 1'b1);
    drain();
    // bouncing with 2-cycle phases never qualifies
    for (int i = 0; i < 12; i++) begin
      key_raw[0] = (i % 2 == 1);
      expect_at(cyc + 1, "bounce", 4'h0, 4'h0, 1'b0);
      tick();
      expect_at(cyc + 1, "bounce", 4'h0, 4'h0, 1'b0);
      tick();
    end
    key_raw[0] = 1'b1;
    c = cyc;
    for (int i = 1; i <= 10; i++) expect_at(c + i, "bounce_end", 4'h0, 4'h0, i >= 6);
    drain();
    // single-cycle release glitch while pressed is ignored
    c = cyc;
    key_raw[0] = 1'b0;
    expect_at(c + 7, "g_press", 4'h1, 4'h0, 1'b1);
    drain();
    c = cyc;
    key_raw[0] = 1'b1;
    expect_at(c + 1, "glitch", 4'h1, 4'h0, 1'b0);
    tick();
    key_raw[0] = 1'b0;
    for (int i = 1; i <= 8; i++) expect_at(cyc + i, "glitch", 4'h1, 4'h0, 1'b0);
    expect_at(cyc + 9, "glitch_end", 4'h1, 4'h0, 1'b1);
    drain();
    c = cyc;
    key_raw[0] = 1'b1;
    expect_at(c + 6, "g_rel_last", 4'h1, 4'h1, 1'b1);
    expect_at(c + 7, "g_rel", 4'h0, 4'h0, 1'b1);
    drain();
    // reset mid-wait restarts the full latency
    c = cyc;
    key_raw[0] = 1'b0;
    expect_at(c + 3, "m_busy", 4'h0, 4'h1, 1'b1);
    expect_at(c + 5, "m_cnt2", 4'h0, 4'h1, 1'b1);
    tick(5);
    reset = 1'b1;
    expect_at(c + 6, "m_rst", 4'h0, 4'h0, 1'b1);
    tick();
    reset = 1'b0;
    expect_at(c + 8, "m_idle", 4'h0, 4'h0, 1'b1);
    expect_at(c + 9, "m_busy2", 4'h0, 4'h1, 1'b1);
    expect_at(c + 12, "m_last", 4'h0, 4'h1, 1'b1);
    expect_at(c + 13, "m_clean", 4'h1, 4'h0, 1'b1);
    drain();
    c = cyc;
    key_raw = 4'hF;
    expect_at(c + 7, "m_rel", 4'h0, 4'h0, 1'b1);
    drain();
    // two keys staggered by two cycles are independent
    c = cyc;
    key_raw[0] = 1'b0;
    expect_at(c + 6, "x_pre", 4'h0, 4'h0, 1'b0);
    expect_at(c + 7, "x_k0", 4'h1, 4'h0, 1'b0);
    expect_at(c + 8, "x_k0b", 4'h1, 4'h0, 1'b0);
    expect_at(c + 9, "x_k3", 4'b1001, 4'h0, 1'b1);
    expect_at(c + 12, "x_hold", 4'b1001, 4'h0, 1'b1);
    tick(2);
    key_raw[3] = 1'b0;
    drain();
    c = cyc;
    key_raw = 4'hF;
    expect_at(c + 7, "x_rel", 4'h0, 4'h0, 1'b1);
    drain();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
